// File: rtl/mem_line_responder_pkg.sv
// rtl/mem_line_responder_pkg.sv - shared types and helpers for the cache line memory responder
package mem_pkg;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} resp_state_t;

  // Line number of a byte address; callers truncate it to their index width.
  function automatic logic [31:0] line_idx(input logic [31:0] addr);
    return addr >> OFFSET_W;
  endfunction
endpackage

// File: rtl/mem_line_responder_if.sv
// rtl/mem_line_responder_if.sv - cache-to-memory line request/acknowledge bus
interface mem_line_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [DATA_W-1:0] data_o;
  logic              busy_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o, busy_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o, busy_o
  );
endinterface

// File: rtl/mem_line_responder_line_sram.sv
// rtl/mem_line_responder_line_sram.sv - single-port line array with registered read
import mem_pkg::*;

module line_sram #(
  parameter int DATA_W = LINE_W,
  parameter int DEPTH  = 512
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);
  // The array is deliberately unreset so its contents survive reset and can be preloaded.
  logic [DATA_W-1:0] memory [DEPTH];

  always @(posedge clk_i) begin
    if (en && we) begin
      memory[addr] <= wdata;
    end
  end

  // Read register only moves on a read, so it holds the last read line.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= memory[addr];
    end
  end
endmodule

// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - fixed-latency responder completing one line read/write per request
import mem_pkg::*;

module mem_line_responder #(
  parameter int DATA_W  = LINE_W,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic     clk_i,
  input  logic     rst_i,
  mem_line_if.slave bus
);
  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

  resp_state_t       state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic              capture;
  logic              access;

  // Truncating the line number to IDX_W bits gives the modulo-DEPTH wrap.
  assign idx_d = IDX_W'(line_idx(32'(bus.addr_i)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          capture = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          access  = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        idx_q   <= idx_d;
        write_q <= bus.write_i;
        wdata_q <= bus.data_i;
      end
    end
  end

  assign bus.ack_o  = (state_q == ACK);
  assign bus.busy_o = (state_q != IDLE);

  line_sram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) line_sram (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en     (access),
    .we     (write_q),
    .addr   (idx_q),
    .wdata  (wdata_q),
    .rdata  (bus.data_o)
  );
endmodule

// File: tb/tb_mem_line_responder.sv
// tb/tb_mem_line_responder.sv - directed scoreboard bench for the line memory responder
module tb_mem_line_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [255:0] sb [$];
  logic [255:0] last_rd = '0;
  logic [255:0] exp_v;
  bit saw_ack;

  localparam logic [255:0] L0   = 256'h5;
  localparam logic [255:0] L1   = 256'hAAAA_0001;
  localparam logic [255:0] L2   = 256'h2222_0002;
  localparam logic [255:0] L3   = 256'h1234_0003;
  localparam logic [255:0] BEEF = {8{32'hDEADBEEF}};
  localparam logic [255:0] L77  = 256'h77;

  always #5 clk = ~clk;

  mem_line_if #(.DATA_W(256), .ADDR_W(32)) bus ();
  mem_line_if #(.DATA_W(256), .ADDR_W(32)) bus1 ();

  mem_line_responder #(.DATA_W(256), .ADDR_W(32), .DEPTH(512), .LATENCY(10)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  mem_line_responder #(.DATA_W(256), .ADDR_W(32), .DEPTH(512), .LATENCY(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus1.slave)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic wr, input logic [255:0] data);
    @(negedge clk);
    bus.addr_i   = addr;
    bus.write_i  = wr;
    bus.data_i   = data;
    bus.enable_i = 1'b1;
  endtask

  // Starts at the capture edge, counts edges to the ack and checks the ack cycle.
  task automatic await_ack(input string tag, input int exp_lat, input bit is_read, input bit perturb);
    int  edges;
    bit  got;
    edges = 0;
    got   = 1'b0;
    @(posedge clk);
    #1;
    if (perturb) begin
      bus.addr_i   = 32'h0000_0040;
      bus.enable_i = 1'b0;
    end
    while (edges < 50) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1 && exp_lat > 1) check({tag, "_busy"}, 256'(bus.busy_o), 256'(1'b1));
      if (bus.ack_o) begin
        got = 1'b1;
        break;
      end
    end
    bus.enable_i = 1'b0;
    check({tag, "_latency"}, 256'(edges), 256'(exp_lat));
    if (got) begin
      if (is_read) begin
        exp_v = sb.pop_front();
        check({tag, "_rdata"}, bus.data_o, exp_v);
        last_rd = exp_v;
      end else begin
        check({tag, "_data_hold"}, bus.data_o, last_rd);
      end
      @(posedge clk);
      #1;
      check({tag, "_ack_single"}, 256'(bus.ack_o), 256'(1'b0));
    end
  endtask

  initial begin
    bus.addr_i = '0; bus.data_i = '0; bus.enable_i = 1'b0; bus.write_i = 1'b0;
    bus1.addr_i = '0; bus1.data_i = '0; bus1.enable_i = 1'b0; bus1.write_i = 1'b0;
    #1;
    for (int i = 0; i < 512; i++) begin
      dut.line_sram.memory[i]  = '0;
      dut1.line_sram.memory[i] = '0;
    end
    dut.line_sram.memory[0] = L0;
    dut.line_sram.memory[1] = L1;
    dut.line_sram.memory[2] = L2;
    dut.line_sram.memory[3] = L3;
    dut1.line_sram.memory[0] = L77;
    repeat (2) @(negedge clk);
    check("rst_ack", 256'(bus.ack_o), 256'(1'b0));
    check("rst_busy", 256'(bus.busy_o), 256'(1'b0));
    check("rst_data", bus.data_o, '0);
    rst_n = 1'b1;

    // Read after preload
    sb.push_back(L0);
    drive(32'h0000_0000, 1'b0, '0);
    await_ack("rd0", 10, 1'b1, 1'b0);

    // Write then read back
    drive(32'h0000_0400, 1'b1, BEEF);
    await_ack("wr32", 10, 1'b0, 1'b0);
    check("wr32_mem", dut.line_sram.memory[32], BEEF);
    sb.push_back(BEEF);
    drive(32'h0000_0400, 1'b0, '0);
    await_ack("rd32", 10, 1'b1, 1'b0);

    // Inputs change after capture
    sb.push_back(L1);
    drive(32'h0000_0020, 1'b0, '0);
    await_ack("perturb", 10, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("perturb_no_second", 256'(bus.busy_o), 256'(1'b0));

    // Offset and high bits ignored
    sb.push_back(L0);
    drive(32'h4000_001F, 1'b0, '0);
    await_ack("wrap", 10, 1'b1, 1'b0);

    // Reset five edges into a write
    drive(32'h0000_0060, 1'b1, 256'hFF);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.enable_i = 1'b0;
    #1;
    check("abort_ack", 256'(bus.ack_o), 256'(1'b0));
    check("abort_busy", 256'(bus.busy_o), 256'(1'b0));
    check("abort_data", bus.data_o, '0);
    saw_ack = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.ack_o) saw_ack = 1'b1;
    end
    check("abort_no_ack", 256'(saw_ack), 256'(1'b0));
    check("abort_mem3", dut.line_sram.memory[3], L3);

    // Release mid-cycle with a request already pending
    last_rd = '0;
    @(negedge clk);
    bus.addr_i = 32'h0000_0060; bus.write_i = 1'b0; bus.enable_i = 1'b1;
    sb.push_back(L3);
    #2;
    rst_n = 1'b1;
    await_ack("post_rst", 10, 1'b1, 1'b0);

    // LATENCY=1 with enable held high
    @(negedge clk);
    bus1.addr_i = 32'h0; bus1.write_i = 1'b0; bus1.enable_i = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat1_ack_e%0d", k), 256'(bus1.ack_o), 256'((k % 3) == 1));
      if ((k % 3) == 1) check($sformatf("lat1_data_e%0d", k), bus1.data_o, L77);
    end
    bus1.enable_i = 1'b0;

    check("sb_empty", 256'(sb.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
